// File: rtl/ulss_wrr_grant_scheduler.sv
// Weighted round-robin read-grant scheduler: 16 packet-store queues onto 4 output
// ports, one independent IDLE/GRANT arbiter per port over its group of 4 queues.
module ulss_wrr_grant_scheduler #(
  parameter int unsigned NUM_Q  = 16,
  parameter int unsigned NUM_P  = 4,
  parameter int unsigned WGT_W  = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 64
) (
  input  logic              rate_limiter_16to4_clk,
  input  logic              rate_limiter_16to4_rstn,
  input  logic              rate_limiter_16to4_sw_rst,
  input  logic              sch_reg_wr_en,
  input  logic [ADDR_W-1:0] sch_reg_wr_addr,
  input  logic [DATA_W-1:0] sch_reg_wr_data,
  input  logic [NUM_Q-1:0]  pck_str_empty,
  input  logic [NUM_P-1:0]  port_eop,
  output logic [NUM_Q-1:0]  pck_rd_en_grnt,
  output logic [NUM_P-1:0]  sch_port_busy
);

  localparam int unsigned QPP   = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                       state   [NUM_P];
  logic [SEL_W-1:0]             rr_ptr  [NUM_P];
  logic [SEL_W-1:0]             gnt_idx [NUM_P];
  logic [WGT_W-1:0]             weight  [NUM_P][QPP];
  logic [WGT_W-1:0]             credit  [NUM_P][QPP];
  logic                         sch_en;
  logic [NUM_P-1:0][QPP-1:0]    grnt_q;

  logic [NUM_P-1:0][QPP-1:0]    act_c;
  logic [NUM_P-1:0][QPP-1:0]    elig_c;
  logic [NUM_P-1:0]             sel_vld_c;
  logic [NUM_P-1:0]             reload_c;
  logic [SEL_W-1:0]             sel_idx_c [NUM_P];

  // Upper write-data bits carry no register field.
  logic unused_wr_data;
  assign unused_wr_data = ^sch_reg_wr_data[DATA_W-1:WGT_W];

  assign pck_rd_en_grnt = grnt_q;

  // Eligibility and rotating first-eligible pick starting at rr_ptr, per port.
  always_comb begin
    act_c     = '0;
    elig_c    = '0;
    sel_vld_c = '0;
    reload_c  = '0;
    for (int p = 0; p < NUM_P; p++) sel_idx_c[p] = '0;
    for (int p = 0; p < NUM_P; p++) begin
      for (int k = 0; k < QPP; k++) begin
        act_c[p][k]  = !pck_str_empty[p*QPP+k] && (weight[p][k] != '0);
        elig_c[p][k] = act_c[p][k] && (credit[p][k] != '0);
      end
    end
    for (int p = 0; p < NUM_P; p++) begin
      // Scan from the farthest offset down so the nearest eligible queue wins.
      for (int i = QPP-1; i >= 0; i--) begin
        if (elig_c[p][SEL_W'(rr_ptr[p] + SEL_W'(i))]) begin
          sel_vld_c[p] = 1'b1;
          sel_idx_c[p] = SEL_W'(rr_ptr[p] + SEL_W'(i));
        end
      end
      reload_c[p] = (|act_c[p]) && !sel_vld_c[p];
    end
  end

  // Register writes, per-port arbiter FSMs, credit bookkeeping and registered outputs.
  always_ff @(posedge rate_limiter_16to4_clk or negedge rate_limiter_16to4_rstn) begin
    if (!rate_limiter_16to4_rstn) begin
      sch_en        <= 1'b1;
      grnt_q        <= '0;
      sch_port_busy <= '0;
      for (int p = 0; p < NUM_P; p++) begin
        state[p]   <= IDLE;
        rr_ptr[p]  <= '0;
        gnt_idx[p] <= '0;
        for (int k = 0; k < QPP; k++) begin
          weight[p][k] <= WGT_W'(1);
          credit[p][k] <= WGT_W'(1);
        end
      end
    end else if (rate_limiter_16to4_sw_rst) begin
      // Soft reset keeps the programmed weights and the enable.
      grnt_q        <= '0;
      sch_port_busy <= '0;
      for (int p = 0; p < NUM_P; p++) begin
        state[p]   <= IDLE;
        rr_ptr[p]  <= '0;
        gnt_idx[p] <= '0;
        for (int k = 0; k < QPP; k++) credit[p][k] <= WGT_W'(1);
      end
    end else begin
      if (sch_reg_wr_en) begin
        if (sch_reg_wr_addr < ADDR_W'(NUM_Q)) begin
          weight[sch_reg_wr_addr[3:2]][sch_reg_wr_addr[1:0]] <= sch_reg_wr_data[WGT_W-1:0];
        end else if (sch_reg_wr_addr == ADDR_W'(NUM_Q)) begin
          sch_en <= sch_reg_wr_data[0];
        end
      end
      for (int p = 0; p < NUM_P; p++) begin
        if (state[p] == IDLE) begin
          if (sch_en && sel_vld_c[p]) begin
            gnt_idx[p]       <= sel_idx_c[p];
            grnt_q[p]        <= QPP'(1) << sel_idx_c[p];
            sch_port_busy[p] <= 1'b1;
            state[p]         <= GRANT;
          end else if (sch_en && reload_c[p]) begin
            // Reload reads the pre-write weight, so a same-cycle write lands next round.
            for (int k = 0; k < QPP; k++) credit[p][k] <= weight[p][k];
          end
        end else if (port_eop[p]) begin
          if (credit[p][gnt_idx[p]] != '0) begin
            credit[p][gnt_idx[p]] <= credit[p][gnt_idx[p]] - WGT_W'(1);
          end
          rr_ptr[p]        <= SEL_W'(gnt_idx[p] + SEL_W'(1));
          grnt_q[p]        <= '0;
          sch_port_busy[p] <= 1'b0;
          state[p]         <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ulss_wrr_grant_scheduler.sv
// Bench for the WRR grant scheduler: queue-level reference model, per-cycle compare,
// directed scenarios with literal grant orders, then a randomized soak.
module tb_ulss_wrr_grant_scheduler;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sw_rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [15:0] empty = '1;
  logic [3:0]  port_eop = '0;
  logic [15:0] grnt;
  logic [3:0]  busy;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;
  int eop_mode = 0;   // 0 none, 1 three-beat packets, 2 random

  // Reference model: granted queue per port (-1 = none), credits, weights, pointers.
  int m_w[16];
  int m_c[16];
  int m_gq[4];
  int m_rr[4];
  bit m_en;
  int glog[4][0:15];  // per-port grant history; 99 marks a reload cycle
  int gn[4];
  int bcnt[4];

  ulss_wrr_grant_scheduler dut (
    .rate_limiter_16to4_clk   (clk),
    .rate_limiter_16to4_rstn  (rstn),
    .rate_limiter_16to4_sw_rst(sw_rst),
    .sch_reg_wr_en            (wr_en),
    .sch_reg_wr_addr          (wr_addr),
    .sch_reg_wr_data          (wr_data),
    .pck_str_empty            (empty),
    .port_eop                 (port_eop),
    .pck_rd_en_grnt           (grnt),
    .sch_port_busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset(input bit full);
    for (int q = 0; q < 16; q++) begin
      m_c[q] = 1;
      if (full) m_w[q] = 1;
    end
    for (int p = 0; p < 4; p++) begin
      m_gq[p] = -1;
      m_rr[p] = 0;
    end
    if (full) m_en = 1'b1;
  endtask

  task automatic log_ev(input int p, input int v);
    if (gn[p] < 16) begin
      glog[p][gn[p]] = v;
      gn[p]++;
    end
  endtask

  task automatic model_step();
    if (sw_rst) begin
      model_reset(1'b0);
      return;
    end
    for (int p = 0; p < 4; p++) begin
      if (m_gq[p] < 0) begin
        if (m_en) begin
          int pick = -1;
          bit any = 1'b0;
          for (int i = 0; i < 4; i++) begin
            int q = 4*p + (m_rr[p] + i) % 4;
            if (pick < 0 && !empty[q] && m_w[q] != 0 && m_c[q] != 0) pick = q;
            if (!empty[4*p+i] && m_w[4*p+i] != 0) any = 1'b1;
          end
          if (pick >= 0) begin
            m_gq[p] = pick;
            log_ev(p, pick);
          end else if (any) begin
            for (int k = 0; k < 4; k++) m_c[4*p+k] = m_w[4*p+k];
            log_ev(p, 99);
          end
        end
      end else if (port_eop[p]) begin
        if (m_c[m_gq[p]] > 0) m_c[m_gq[p]]--;
        m_rr[p] = (m_gq[p] % 4 + 1) % 4;
        m_gq[p] = -1;
      end
    end
    if (wr_en) begin
      if (wr_addr < 5'd16) m_w[wr_addr] = int'(wr_data[7:0]);
      else if (wr_addr == 5'd16) m_en = wr_data[0];
    end
  endtask

  function automatic logic [15:0] exp_grant();
    logic [15:0] v = '0;
    for (int p = 0; p < 4; p++) if (m_gq[p] >= 0) v[m_gq[p]] = 1'b1;
    return v;
  endfunction

  function automatic logic [3:0] exp_busy();
    logic [3:0] v = '0;
    for (int p = 0; p < 4; p++) v[p] = (m_gq[p] >= 0);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model advances on the same edge as the DUT; async reset clears it at once.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset(1'b1);
    else model_step();
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("grant", 32'(grnt), 32'(exp_grant()));
      chk("busy", 32'(busy), 32'(exp_busy()));
    end
  end

  // End-of-packet driver, keyed off the model's view of which ports are granted.
  always begin
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      if (m_gq[p] >= 0) bcnt[p]++;
      else bcnt[p] = 0;
      case (eop_mode)
        1:       port_eop[p] = (bcnt[p] >= 3);
        2:       port_eop[p] = ($urandom % 3 == 0);
        default: port_eop[p] = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int p = 0; p < 4; p++) gn[p] = 0;
  endtask

  task automatic do_reset();
    eop_mode = 0;
    empty = '1;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic wr(input int a, input logic [63:0] d);
    wr_en = 1'b1;
    wr_addr = 5'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_gn(input int p, input int n, input int budget);
    int c = 0;
    while (gn[p] < n && c < budget) begin
      tick();
      c++;
    end
    total++;
    if (gn[p] < n) begin
      bad++;
      $display("FAIL wait_log_p%0d: got %0d entries expected %0d", p, gn[p], n);
    end
  endtask

  task automatic wait_busy(input int p, input int budget);
    int c = 0;
    while (m_gq[p] < 0 && c < budget) begin
      tick();
      c++;
    end
    total++;
    if (m_gq[p] < 0) begin
      bad++;
      $display("FAIL wait_busy_p%0d: got idle expected grant", p);
    end
  endtask

  task automatic check_log(input int p, input int n, input int e[10], input string nm);
    for (int i = 0; i < n; i++) chk($sformatf("%s[%0d]", nm, i), 32'(glog[p][i]), 32'(e[i]));
  endtask

  initial begin
    bit saw4 = 1'b0;
    model_reset(1'b1);
    clear_logs();
    tick();
    chk("reset_grant", 32'(grnt), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rstn = 1'b1;
    chk_on = 1'b1;
    tick();

    // Async reset mid-grant; weight 0 on q0 must be restored to 1.
    empty = 16'hFFFE;
    wait_busy(0, 20);
    wr(0, 64'h0);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_grant", 32'(grnt), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    tick();
    rstn = 1'b1;
    clear_logs();
    eop_mode = 1;
    wait_gn(0, 1, 20);
    chk("rst_weight_q0", 32'(glog[0][0]), 32'd0);

    // Default weights on port 0.
    do_reset();
    clear_logs();
    empty = 16'hFFF0;
    eop_mode = 1;
    wait_gn(0, 7, 200);
    check_log(0, 7, '{0, 1, 2, 3, 99, 0, 1, 0, 0, 0}, "order_p0");

    // Weights 3/1 on q4/q5; starting credits are the reset value of 1.
    do_reset();
    wr(4, 64'd3);
    wr(5, 64'd1);
    clear_logs();
    empty = 16'hFFCF;
    eop_mode = 1;
    wait_gn(1, 10, 300);
    check_log(1, 10, '{4, 5, 99, 4, 5, 4, 4, 99, 5, 4}, "wrr_p1");

    // Disabled q8.
    do_reset();
    wr(8, 64'd0);
    clear_logs();
    empty = 16'hF0FF;
    eop_mode = 1;
    wait_gn(2, 7, 200);
    check_log(2, 7, '{9, 10, 11, 99, 9, 10, 11, 0, 0, 0}, "skip_q8");

    // All queues busy with random packet ends: all four ports granted together.
    do_reset();
    empty = '0;
    eop_mode = 2;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (busy == 4'hF) saw4 = 1'b1;
    end
    chk("concurrent4", 32'(saw4), 32'h1);

    // Soft reset mid-grant keeps weights; then disable stops new grants.
    do_reset();
    wr(9, 64'd2);
    empty = '0;
    eop_mode = 0;
    wait_busy(2, 20);
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    chk("swrst_grant", 32'(grnt), 32'h0);
    chk("swrst_busy", 32'(busy), 32'h0);
    clear_logs();
    eop_mode = 1;
    wait_gn(2, 10, 300);
    check_log(2, 10, '{8, 9, 10, 11, 99, 8, 9, 10, 11, 9}, "swrst_keep_w");
    wr(16, 64'd0);
    repeat (20) tick();
    chk("disabled_grant", 32'(grnt), 32'h0);
    chk("disabled_busy", 32'(busy), 32'h0);
    wr(16, 64'd1);

    // Randomized soak.
    do_reset();
    eop_mode = 2;
    for (int i = 0; i < 2500; i++) begin
      for (int q = 0; q < 16; q++) empty[q] = ($urandom % 3 == 0);
      wr_en = ($urandom % 8 == 0);
      sw_rst = !wr_en && ($urandom % 100 == 0);
      wr_addr = 5'($urandom);
      wr_data = {$urandom, $urandom};
      if ($urandom % 4 != 0) wr_data[7:0] = 8'($urandom_range(0, 3));
      if (wr_addr == 5'd16) wr_data[0] = ($urandom % 4 != 0);
      tick();
    end
    wr_en = 1'b0;
    sw_rst = 1'b0;
    tick();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
